// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph row scanner: glyph geometry, FSM encodings,
// the double-buffered glyph pair and the row-group extraction helper.
package glyph_pkg;

   localparam int GLYPH_ROWS = 5;
   localparam int GLYPH_COLS = 3;
   localparam int GLYPH_BITS = 15;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam logic [1:0] SO_IDLE  = 2'd0;
   localparam logic [1:0] SO_SHIFT = 2'd1;
   localparam logic [1:0] SO_LATCH = 2'd2;

   typedef struct packed {
      logic [GLYPH_BITS-1:0] left;
      logic [GLYPH_BITS-1:0] right;
   } glyph_pair_t;

   // Row 0 is the top row and sits in the most significant group.
   function automatic logic [GLYPH_COLS-1:0] glyph_row(input logic [GLYPH_BITS-1:0] bitmap,
                                                       input logic [2:0] r);
      case (r)
         3'd0:    glyph_row = bitmap[14:12];
         3'd1:    glyph_row = bitmap[11:9];
         3'd2:    glyph_row = bitmap[8:6];
         3'd3:    glyph_row = bitmap[5:3];
         default: glyph_row = bitmap[2:0];
      endcase
   endfunction

endpackage

// File: rtl/glyph_shift_out.sv
// Parallel-load serializer: shifts a W-bit column word MSB first with a CLK_DIV
// prescaled ser_clk, then pulses ser_latch for CLK_DIV cycles.
module glyph_shift_out
   import glyph_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int W       = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] word,
   output logic         ser_data,
   output logic         ser_clk,
   output logic         ser_latch,
   output logic         shift_end,
   output logic         done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(W);

   logic [1:0]    phase_q, phase_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          half_q, half_d;
   logic          ser_data_q, ser_data_d;
   logic          ser_clk_q, ser_clk_d;
   logic          ser_latch_q, ser_latch_d;
   logic          div_last;

   assign div_last = (div_cnt_q == DW'(CLK_DIV - 1));

   // Next-state and next-output logic; shift_end/done flag the last cycle of each phase.
   always_comb begin
      phase_d     = phase_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      half_d      = half_q;
      ser_data_d  = ser_data_q;
      ser_clk_d   = ser_clk_q;
      ser_latch_d = ser_latch_q;
      shift_end   = 1'b0;
      done        = 1'b0;
      case (phase_q)
         SO_IDLE: begin
            if (start) begin
               phase_d     = SO_SHIFT;
               shreg_d     = word;
               bit_cnt_d   = {BW{1'b0}};
               div_cnt_d   = {DW{1'b0}};
               half_d      = 1'b0;
               ser_data_d  = word[W-1];
               ser_clk_d   = 1'b0;
               ser_latch_d = 1'b0;
            end else begin
               ser_data_d  = 1'b0;
               ser_clk_d   = 1'b0;
               ser_latch_d = 1'b0;
            end
         end
         SO_SHIFT: begin
            if (!div_last) begin
               div_cnt_d = div_cnt_q + DW'(1);
            end else if (!half_q) begin
               div_cnt_d = {DW{1'b0}};
               half_d    = 1'b1;
               ser_clk_d = 1'b1;
            end else if (bit_cnt_q != BW'(W - 1)) begin
               div_cnt_d  = {DW{1'b0}};
               half_d     = 1'b0;
               ser_clk_d  = 1'b0;
               bit_cnt_d  = bit_cnt_q + BW'(1);
               shreg_d    = {shreg_q[W-2:0], 1'b0};
               ser_data_d = shreg_q[W-2];
            end else begin
               div_cnt_d   = {DW{1'b0}};
               half_d      = 1'b0;
               ser_clk_d   = 1'b0;
               ser_data_d  = 1'b0;
               ser_latch_d = 1'b1;
               phase_d     = SO_LATCH;
               shift_end   = 1'b1;
            end
         end
         SO_LATCH: begin
            if (!div_last) begin
               div_cnt_d = div_cnt_q + DW'(1);
            end else begin
               div_cnt_d   = {DW{1'b0}};
               ser_latch_d = 1'b0;
               phase_d     = SO_IDLE;
               done        = 1'b1;
            end
         end
         default: begin
            phase_d     = SO_IDLE;
            ser_data_d  = 1'b0;
            ser_clk_d   = 1'b0;
            ser_latch_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= SO_IDLE;
         shreg_q     <= {W{1'b0}};
         bit_cnt_q   <= {BW{1'b0}};
         div_cnt_q   <= {DW{1'b0}};
         half_q      <= 1'b0;
         ser_data_q  <= 1'b0;
         ser_clk_q   <= 1'b0;
         ser_latch_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         half_q      <= half_d;
         ser_data_q  <= ser_data_d;
         ser_clk_q   <= ser_clk_d;
         ser_latch_q <= ser_latch_d;
      end
   end

   assign ser_data  = ser_data_q;
   assign ser_clk   = ser_clk_q;
   assign ser_latch = ser_latch_q;

endmodule

// File: rtl/glyph_row_scanner.sv
// Row-multiplexed driver for a 5 x (6+GAP_COLS) LED matrix showing two 3x5 glyphs,
// with double-buffered glyph inputs committed only at frame boundaries.
module glyph_row_scanner
   import glyph_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int ROW_HOLD = 1000,
   parameter int GAP_COLS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [GLYPH_BITS-1:0] glyph_left,
   input  logic [GLYPH_BITS-1:0] glyph_right,
   input  logic                  load,
   output logic                  ser_data,
   output logic                  ser_clk,
   output logic                  ser_latch,
   output logic [4:0]            row_sel,
   output logic                  frame_done
);

   localparam int W  = 6 + GAP_COLS;
   localparam int HW = $clog2(ROW_HOLD + 1);

   logic [1:0]    state_q, state_d;
   logic [2:0]    row_q, row_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [4:0]    row_sel_q, row_sel_d;
   logic          frame_done_q, frame_done_d;
   glyph_pair_t   active_q, active_d;
   glyph_pair_t   pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;

   glyph_pair_t   in_pair_s;
   logic [W-1:0]  word_s;
   logic          start_s;
   logic          frame_start_s;
   logic          shift_end_s;
   logic          done_s;

   assign in_pair_s = '{left: glyph_left, right: glyph_right};

   // Scan sequencing: row counter, hold timer and blanked row enables.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      hold_cnt_d    = hold_cnt_q;
      row_sel_d     = row_sel_q;
      frame_done_d  = 1'b0;
      start_s       = 1'b0;
      frame_start_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_valid_q) begin
               start_s       = 1'b1;
               frame_start_s = 1'b1;
               row_d         = 3'd0;
               state_d       = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (shift_end_s) begin
               state_d = ST_LATCH;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_LATCH: begin
            if (done_s) begin
               state_d    = ST_HOLD;
               hold_cnt_d = {HW{1'b0}};
               row_sel_d  = 5'b00001 << row_q;
            end else begin
               state_d = ST_LATCH;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q == HW'(ROW_HOLD - 1)) begin
               row_sel_d = 5'b00000;
               start_s   = 1'b1;
               state_d   = ST_SHIFT;
               if (row_q == 3'(GLYPH_ROWS - 1)) begin
                  row_d         = 3'd0;
                  frame_done_d  = 1'b1;
                  frame_start_s = 1'b1;
               end else begin
                  row_d = row_q + 3'd1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            row_sel_d = 5'b00000;
         end
      endcase
   end

   // A load coinciding with a frame start bypasses pending and shows in that frame.
   always_comb begin
      active_d     = active_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (frame_start_s && load) begin
         active_d     = in_pair_s;
         pend_valid_d = 1'b0;
      end else if (frame_start_s && pend_valid_q) begin
         active_d     = pend_q;
         pend_valid_d = 1'b0;
      end else if (load) begin
         pend_d       = in_pair_s;
         pend_valid_d = 1'b1;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // Column word for the row about to be shifted, built from the post-commit buffer.
   always_comb begin
      word_s          = {W{1'b0}};
      word_s[2:0]     = glyph_row(active_d.left, row_d);
      word_s[W-1:W-3] = glyph_row(active_d.right, row_d);
   end

   // Scanner registers with synchronous reset; load is ignored while rst is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         row_q        <= 3'd0;
         hold_cnt_q   <= {HW{1'b0}};
         row_sel_q    <= 5'b00000;
         frame_done_q <= 1'b0;
         active_q     <= '{left: 15'd0, right: 15'd0};
         pend_q       <= '{left: 15'd0, right: 15'd0};
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         hold_cnt_q   <= hold_cnt_d;
         row_sel_q    <= row_sel_d;
         frame_done_q <= frame_done_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   glyph_shift_out #(
      .CLK_DIV (CLK_DIV),
      .W       (W)
   ) u_shift_out (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s),
      .word      (word_s),
      .ser_data  (ser_data),
      .ser_clk   (ser_clk),
      .ser_latch (ser_latch),
      .shift_end (shift_end_s),
      .done      (done_s)
   );

   assign row_sel    = row_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_glyph_row_scanner.sv
// Randomized bench for glyph_row_scanner; expected outputs come from a cycle-position
// model of the scan schedule and a "latest load at or before the frame boundary" rule.
module tb_glyph_row_scanner;

   localparam int CD        = 1;
   localparam int RH        = 4;
   localparam int GAP       = 1;
   localparam int W         = 6 + GAP;
   localparam int SHIFT_LEN = 2 * CD * W;
   localparam int PER       = SHIFT_LEN + CD + RH;
   localparam int FRAME     = 5 * PER;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [14:0] gl = 15'd0;
   logic [14:0] gr = 15'd0;
   logic        ser_data, ser_clk, ser_latch, frame_done;
   logic [4:0]  row_sel;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          running = 1'b0;
   int          s0 = 0;
   int          ld_cyc[$];
   logic [14:0] ld_l[$];
   logic [14:0] ld_r[$];

   always #5 clk = ~clk;

   glyph_row_scanner #(
      .CLK_DIV  (CD),
      .ROW_HOLD (RH),
      .GAP_COLS (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .glyph_left  (gl),
      .glyph_right (gr),
      .load        (load),
      .ser_data    (ser_data),
      .ser_clk     (ser_clk),
      .ser_latch   (ser_latch),
      .row_sel     (row_sel),
      .frame_done  (frame_done)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   // Matrix column col of glyph row `row`: left glyph in cols 0..2, right in W-3..W-1.
   function automatic logic exp_col(input logic [14:0] l, input logic [14:0] r,
                                    input int row, input int col);
      int base;
      base = 12 - 3 * row;
      if (col < 3) return l[base + col];
      else if (col >= W - 3) return r[base + col - (W - 3)];
      else return 1'b0;
   endfunction

   // {care_data, ser_data, ser_clk, ser_latch, row_sel[4:0], frame_done} for cycle c.
   function automatic logic [9:0] model(input int c);
      int off, k, ro, r, p, b, bnd;
      logic [14:0] l, rr;
      logic d, sc, sl, fd, care;
      logic [4:0] rs;
      d = 1'b0; sc = 1'b0; sl = 1'b0; fd = 1'b0; care = 1'b1; rs = 5'd0;
      if (running && c >= s0) begin
         off = c - s0;
         k   = off / FRAME;
         ro  = off % FRAME;
         r   = ro / PER;
         p   = ro % PER;
         fd  = (off > 0 && ro == 0);
         bnd = s0 + FRAME * k - 1;
         l = 15'd0; rr = 15'd0;
         foreach (ld_cyc[i]) begin
            if (ld_cyc[i] <= bnd) begin
               l  = ld_l[i];
               rr = ld_r[i];
            end
         end
         if (p < SHIFT_LEN) begin
            b  = p / (2 * CD);
            sc = ((p % (2 * CD)) >= CD);
            d  = exp_col(l, rr, r, W - 1 - b);
         end else if (p < SHIFT_LEN + CD) begin
            sl   = 1'b1;
            care = 1'b0;
         end else begin
            rs   = 5'(1 << r);
            care = 1'b0;
         end
      end
      return {care, d, sc, sl, rs, fd};
   endfunction

   task automatic cycle_step(input bit do_rst, input bit do_load,
                             input logic [14:0] l, input logic [14:0] r);
      logic [9:0] m;
      rst = do_rst; load = do_load; gl = l; gr = r;
      @(negedge clk);
      m = model(cyc);
      check_eq("outs", {7'd0, ser_data & m[9], ser_clk, ser_latch, row_sel, frame_done},
               {7'd0, m[8:0]});
      check_eq("onehot0", {15'd0, $onehot0(row_sel)}, 16'd1);
      check_eq("blank", {15'd0, (row_sel != 5'd0) && (ser_clk || ser_latch)}, 16'd0);
      if (do_rst) begin
         running = 1'b0;
         ld_cyc.delete(); ld_l.delete(); ld_r.delete();
      end else if (do_load) begin
         ld_cyc.push_back(cyc); ld_l.push_back(l); ld_r.push_back(r);
         if (!running) begin
            running = 1'b1;
            s0 = cyc + 2;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int guard;
      @(posedge clk);
      #1;
      cyc = 0;
      repeat (4) cycle_step(1'b1, 1'b0, 15'($urandom), 15'($urandom));
      repeat (200) cycle_step(1'b0, 1'b0, 15'($urandom), 15'($urandom));
      cycle_step(1'b0, 1'b1, 15'h7B6F, 15'h4924);

      // Random loads only in odd frames so the targeted cases in even frames stay clean.
      for (int i = 0; i < 1200; i++) begin
         int rel;
         bit ld;
         rel = cyc - s0;
         ld  = (((rel / FRAME) % 2) == 1) && ($urandom_range(0, 59) == 0);
         if (rel == FRAME * 2 + 2 * PER + 5) ld = 1'b1;
         if (rel == FRAME * 4 - 1) ld = 1'b1;
         if (rel == FRAME * 6 - 2) ld = 1'b1;
         if (rel == FRAME * 8 - 1) ld = 1'b1;
         cycle_step(1'b0, ld, 15'($urandom), 15'($urandom));
      end

      guard = 0;
      while ((((cyc - s0) % FRAME) != 3 * PER + 6) && guard < 2 * FRAME) begin
         cycle_step(1'b0, 1'b0, 15'($urandom), 15'($urandom));
         guard++;
      end
      check_eq("reach_row3", {15'd0, guard < 2 * FRAME}, 16'd1);
      cycle_step(1'b1, 1'b0, 15'($urandom), 15'($urandom));
      cycle_step(1'b1, 1'b1, 15'($urandom), 15'($urandom));
      repeat (100) cycle_step(1'b0, 1'b0, 15'($urandom), 15'($urandom));

      cycle_step(1'b0, 1'b1, 15'($urandom), 15'($urandom));
      for (int i = 0; i < 400; i++) begin
         cycle_step(1'b0, $urandom_range(0, 79) == 0, 15'($urandom), 15'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
